tl_burst_tracker: RTL and testbench
===================================

TL_BURST_TRACKER -- requirements
Module: tl_burst_tracker

Interface
REQ-001 Parameters (name, default, meaning):
- AddrWidth, 56, TL address width.
- DataWidth, 64, TL data width in bits.
- SizeWidth, 3, TL size field width.
- SourceWidth, 1, TL source width.
- SinkWidth, 1, TL sink width.
- MaxSize, 6, log2 of the largest message in bytes.
REQ-002 Derived constants:
- OffsetWidth = log2(DataWidth/8).
- BeatWidth = max(1, MaxSize-OffsetWidth).
REQ-003 Ports (name, direction, width, meaning):
- clk_i, in, 1, the single clock.
- rst_i, in, 1, reset; synchronous and active-high.
- link_h2d_i, in, packed struct, host-to-device: a_valid/a payload, b_ready, c_valid/c payload, d_ready, e_valid/e payload.
- link_d2h_i, in, packed struct, device-to-host: a_ready, b_valid/b payload, c_ready, d_valid/d payload, e_ready.
REQ-004 Per-channel outputs, each BeatWidth bits, x ∈ {req=A, prb=B, rel=C, gnt=D}:
- x_len_o: total beats minus 1.
- x_idx_o: current beat index.
- x_left_o: beats remaining after the current beat.
REQ-005 Per-channel flag outputs, each 1 bit:
- x_first_o: the current beat is the first beat.
- x_last_o: the current beat is the final beat.
REQ-006 The module is a pure observer: no ready/valid outputs, and it never stalls the link.

Function
REQ-007 Fire for channel x is valid AND ready, both taken from the link structs.
REQ-008 Data-carrying opcodes:
- A: PutFullData(0), PutPartialData(1), ArithmeticData(2), LogicalData(3).
- B: opcodes 0-3.
- C: AccessAckData(1), ProbeAckData(5), ReleaseData(7).
- D: AccessAckData(1), GrantData(5).
- All other opcodes are single-beat.
REQ-009 x_len_o is combinational from the current beat's opcode and size:
- Data-carrying with size > OffsetWidth: len = 2^(size-OffsetWidth) - 1, truncated to BeatWidth bits.
- Otherwise len = 0.
REQ-010 size > MaxSize is illegal; the required response is len saturating at all-ones.
REQ-011 Each channel holds a registered beat counter idx_q of BeatWidth bits:
- On fire with x_last_o = 1, idx_q goes to 0.
- On fire with x_last_o = 0, idx_q increments by 1.
- Without fire, idx_q holds.
REQ-012 Derived outputs:
- x_idx_o = idx_q.
- x_first_o = (idx_q == 0).
- x_last_o = (idx_q == x_len_o).
- x_left_o = x_len_o - idx_q, modulo 2^BeatWidth.
REQ-013 Outputs are meaningful only while x valid is high; the module computes them regardless of valid.
REQ-014 Channel E has no tracker (always single beat); no E outputs exist.
REQ-015 The four channels are fully independent, and simultaneous fires on several channels update each counter in the same cycle.
REQ-016 Latency: zero. Outputs reflect the current-cycle header and the counter value, and idx updates on the clock edge after fire.
REQ-017 Single-beat messages (len = 0) assert both first and last, and leave idx at 0 after fire.
REQ-018 Payload fields beyond opcode and size are ignored.

Reset
REQ-019 While rst_i = 1 at a rising edge, all four idx_q clear to 0, including mid-burst.
REQ-020 After reset:
- first_o = 1 for every channel.
- idx_o = 0 for every channel.
- last_o/len_o/left_o follow the input header combinationally.
REQ-021 A burst interrupted by reset is forgotten; the next fire is treated as beat 0.

Structure
REQ-022 The A/B/C/D opcode enumerations and the h2d/d2h link struct typedefs belong in the shared package tl_pkg, with pack macros in tl_util.svh.
REQ-023 One sub-module is natural: tl_beat_counter, parameterised by BeatWidth.
- Inputs: clk_i, rst_i, fire_i, len_i.
- Outputs: idx_o, left_o, first_o, last_o.
- It is instantiated four times; the opcode/size-to-len decode stays in the top level.

Verification
REQ-024 Test configuration: DataWidth=64, MaxSize=6.
REQ-025 Multi-beat A burst with gaps:
- Stimulus: A PutFullData size 6, fired on 8 beats with gaps.
- Response: req_len_o = 7, idx 0..7, left 7..0, first only on beat 0, last only on beat 7, idx = 0 afterwards.
REQ-026 Single-beat messages on A and D:
- Stimulus: A Get size 6, then D AccessAckData size 3.
- Response: len = 0, first = last = 1, idx remains 0 after each fire.
REQ-027 D burst with backpressure:
- Stimulus: D GrantData size 6 with d_ready toggling every cycle.
- Response: gnt_idx_o advances only on fire, and reaches last at index 7.
REQ-028 Concurrent independent bursts:
- Stimulus: a C ReleaseData size 5 burst concurrent with an A PutPartialData size 4 burst.
- Response: rel_len_o = 3 and req_len_o = 1, with the counters advancing independently.
REQ-029 Reset mid-burst:
- Stimulus: rst_i asserted for 1 cycle at beat 3 of an 8-beat A burst.
- Response: req_idx_o = 0 and req_first_o = 1 in the next cycle.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared TileLink types: channel opcodes, channel payloads and the two link
// direction bundles, plus helpers that classify data-carrying opcodes.
package tl_pkg;

    localparam int TlAddrWidth   = 56;
    localparam int TlDataWidth   = 64;
    localparam int TlSizeWidth   = 3;
    localparam int TlSourceWidth = 1;
    localparam int TlSinkWidth   = 1;
    localparam int TlMaskWidth   = TlDataWidth / 8;

    typedef enum logic [2:0] {
        PutFullData    = 3'd0,
        PutPartialData = 3'd1,
        ArithmeticData = 3'd2,
        LogicalData    = 3'd3,
        Get            = 3'd4,
        Intent         = 3'd5,
        AcquireBlock   = 3'd6,
        AcquirePerm    = 3'd7
    } tl_a_op_e;

    typedef enum logic [2:0] {
        BPutFullData    = 3'd0,
        BPutPartialData = 3'd1,
        BArithmeticData = 3'd2,
        BLogicalData    = 3'd3,
        BGet            = 3'd4,
        BIntent         = 3'd5,
        ProbeBlock      = 3'd6,
        ProbePerm       = 3'd7
    } tl_b_op_e;

    typedef enum logic [2:0] {
        CAccessAck     = 3'd0,
        CAccessAckData = 3'd1,
        CHintAck       = 3'd2,
        ProbeAck       = 3'd4,
        ProbeAckData   = 3'd5,
        Release        = 3'd6,
        ReleaseData    = 3'd7
    } tl_c_op_e;

    typedef enum logic [2:0] {
        DAccessAck     = 3'd0,
        DAccessAckData = 3'd1,
        DHintAck       = 3'd2,
        Grant          = 3'd4,
        GrantData      = 3'd5,
        ReleaseAck     = 3'd6
    } tl_d_op_e;

    typedef struct packed {
        tl_a_op_e                 opcode;
        logic [2:0]               param;
        logic [TlSizeWidth-1:0]   size;
        logic [TlSourceWidth-1:0] source;
        logic [TlAddrWidth-1:0]   address;
        logic [TlMaskWidth-1:0]   mask;
        logic [TlDataWidth-1:0]   data;
        logic                     corrupt;
    } tl_a_t;

    typedef struct packed {
        tl_b_op_e                 opcode;
        logic [1:0]               param;
        logic [TlSizeWidth-1:0]   size;
        logic [TlSourceWidth-1:0] source;
        logic [TlAddrWidth-1:0]   address;
        logic [TlMaskWidth-1:0]   mask;
        logic [TlDataWidth-1:0]   data;
        logic                     corrupt;
    } tl_b_t;

    typedef struct packed {
        tl_c_op_e                 opcode;
        logic [2:0]               param;
        logic [TlSizeWidth-1:0]   size;
        logic [TlSourceWidth-1:0] source;
        logic [TlAddrWidth-1:0]   address;
        logic [TlDataWidth-1:0]   data;
        logic                     corrupt;
    } tl_c_t;

    typedef struct packed {
        tl_d_op_e                 opcode;
        logic [1:0]               param;
        logic [TlSizeWidth-1:0]   size;
        logic [TlSourceWidth-1:0] source;
        logic [TlSinkWidth-1:0]   sink;
        logic                     denied;
        logic [TlDataWidth-1:0]   data;
        logic                     corrupt;
    } tl_d_t;

    typedef struct packed {
        logic [TlSinkWidth-1:0] sink;
    } tl_e_t;

    typedef struct packed {
        logic  a_valid;
        tl_a_t a;
        logic  b_ready;
        logic  c_valid;
        tl_c_t c;
        logic  d_ready;
        logic  e_valid;
        tl_e_t e;
    } tl_h2d_t;

    typedef struct packed {
        logic  a_ready;
        logic  b_valid;
        tl_b_t b;
        logic  c_ready;
        logic  d_valid;
        tl_d_t d;
        logic  e_ready;
    } tl_d2h_t;

    function automatic logic a_has_data(input tl_a_op_e op);
        return op inside {PutFullData, PutPartialData, ArithmeticData, LogicalData};
    endfunction

    function automatic logic b_has_data(input tl_b_op_e op);
        return op inside {BPutFullData, BPutPartialData, BArithmeticData, BLogicalData};
    endfunction

    function automatic logic c_has_data(input tl_c_op_e op);
        return op inside {CAccessAckData, ProbeAckData, ReleaseData};
    endfunction

    function automatic logic d_has_data(input tl_d_op_e op);
        return op inside {DAccessAckData, GrantData};
    endfunction

endpackage

// File: rtl/tl_beat_counter.sv
// Per-channel beat counter: tracks the index of the current beat within a
// burst whose length (beats minus one) is presented combinationally.
module tl_beat_counter #(
    parameter int BeatWidth = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 fire_i,
    input  logic [BeatWidth-1:0] len_i,
    output logic [BeatWidth-1:0] idx_o,
    output logic [BeatWidth-1:0] left_o,
    output logic                 first_o,
    output logic                 last_o
);

    logic [BeatWidth-1:0] idx_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q <= '0;
        end else if (fire_i) begin
            if (last_o) begin
                idx_q <= '0;
            end else begin
                idx_q <= idx_q + BeatWidth'(1);
            end
        end
    end

    assign idx_o   = idx_q;
    assign first_o = (idx_q == '0);
    assign last_o  = (idx_q == len_i);
    assign left_o  = len_i - idx_q;

endmodule

// File: rtl/tl_burst_tracker.sv
// Passive TileLink burst observer: decodes each channel's burst length from
// its header and reports beat position for channels A, B, C and D.
module tl_burst_tracker
    import tl_pkg::*;
#(
    parameter int AddrWidth   = 56,
    parameter int DataWidth   = 64,
    parameter int SizeWidth   = 3,
    parameter int SourceWidth = 1,
    parameter int SinkWidth   = 1,
    parameter int MaxSize     = 6,
    localparam int OffsetWidth = $clog2(DataWidth / 8),
    localparam int BeatWidth   = (MaxSize - OffsetWidth > 1) ? (MaxSize - OffsetWidth) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  tl_h2d_t              link_h2d_i,
    input  tl_d2h_t              link_d2h_i,
    output logic [BeatWidth-1:0] req_len_o,
    output logic [BeatWidth-1:0] req_idx_o,
    output logic [BeatWidth-1:0] req_left_o,
    output logic                 req_first_o,
    output logic                 req_last_o,
    output logic [BeatWidth-1:0] prb_len_o,
    output logic [BeatWidth-1:0] prb_idx_o,
    output logic [BeatWidth-1:0] prb_left_o,
    output logic                 prb_first_o,
    output logic                 prb_last_o,
    output logic [BeatWidth-1:0] rel_len_o,
    output logic [BeatWidth-1:0] rel_idx_o,
    output logic [BeatWidth-1:0] rel_left_o,
    output logic                 rel_first_o,
    output logic                 rel_last_o,
    output logic [BeatWidth-1:0] gnt_len_o,
    output logic [BeatWidth-1:0] gnt_idx_o,
    output logic [BeatWidth-1:0] gnt_left_o,
    output logic                 gnt_first_o,
    output logic                 gnt_last_o
);

    // Link structs come from the package, so the parameters must agree with it.
    if (AddrWidth != TlAddrWidth || DataWidth != TlDataWidth || SizeWidth != TlSizeWidth ||
        SourceWidth != TlSourceWidth || SinkWidth != TlSinkWidth) begin : gen_width_check
        $error("tl_burst_tracker parameters disagree with tl_pkg link widths");
    end

    function automatic logic [BeatWidth-1:0] beat_len(input logic has_data,
                                                      input logic [SizeWidth-1:0] size);
        int          sz;
        logic [31:0] full;
        sz = int'(size);
        if (sz > MaxSize) begin
            return '1;
        end
        if (!has_data || sz <= OffsetWidth) begin
            return '0;
        end
        full = (32'd1 << (sz - OffsetWidth)) - 32'd1;
        return full[BeatWidth-1:0];
    endfunction

    logic req_fire, prb_fire, rel_fire, gnt_fire;

    assign req_fire = link_h2d_i.a_valid & link_d2h_i.a_ready;
    assign prb_fire = link_d2h_i.b_valid & link_h2d_i.b_ready;
    assign rel_fire = link_h2d_i.c_valid & link_d2h_i.c_ready;
    assign gnt_fire = link_d2h_i.d_valid & link_h2d_i.d_ready;

    assign req_len_o = beat_len(a_has_data(link_h2d_i.a.opcode), link_h2d_i.a.size);
    assign prb_len_o = beat_len(b_has_data(link_d2h_i.b.opcode), link_d2h_i.b.size);
    assign rel_len_o = beat_len(c_has_data(link_h2d_i.c.opcode), link_h2d_i.c.size);
    assign gnt_len_o = beat_len(d_has_data(link_d2h_i.d.opcode), link_d2h_i.d.size);

    // Payload beyond opcode/size is observed but deliberately ignored.
    logic unused_link;
    assign unused_link = ^{link_h2d_i, link_d2h_i};

    tl_beat_counter #(.BeatWidth(BeatWidth)) u_req_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .fire_i (req_fire),
        .len_i  (req_len_o),
        .idx_o  (req_idx_o),
        .left_o (req_left_o),
        .first_o(req_first_o),
        .last_o (req_last_o)
    );

    tl_beat_counter #(.BeatWidth(BeatWidth)) u_prb_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .fire_i (prb_fire),
        .len_i  (prb_len_o),
        .idx_o  (prb_idx_o),
        .left_o (prb_left_o),
        .first_o(prb_first_o),
        .last_o (prb_last_o)
    );

    tl_beat_counter #(.BeatWidth(BeatWidth)) u_rel_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .fire_i (rel_fire),
        .len_i  (rel_len_o),
        .idx_o  (rel_idx_o),
        .left_o (rel_left_o),
        .first_o(rel_first_o),
        .last_o (rel_last_o)
    );

    tl_beat_counter #(.BeatWidth(BeatWidth)) u_gnt_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .fire_i (gnt_fire),
        .len_i  (gnt_len_o),
        .idx_o  (gnt_idx_o),
        .left_o (gnt_left_o),
        .first_o(gnt_first_o),
        .last_o (gnt_last_o)
    );

endmodule

// File: tb/tb_tl_burst_tracker.sv
// Directed testbench for tl_burst_tracker with DataWidth=64, MaxSize=6
// (eight-byte beats, up to eight beats per burst, three-bit beat fields).
module tb_tl_burst_tracker;
    import tl_pkg::*;

    logic    clk;
    logic    rst;
    tl_h2d_t h2d;
    tl_d2h_t d2h;

    logic [2:0] req_len, req_idx, req_left;
    logic       req_first, req_last;
    logic [2:0] prb_len, prb_idx, prb_left;
    logic       prb_first, prb_last;
    logic [2:0] rel_len, rel_idx, rel_left;
    logic       rel_first, rel_last;
    logic [2:0] gnt_len, gnt_idx, gnt_left;
    logic       gnt_first, gnt_last;

    int compared   = 0;
    int mismatched = 0;

    tl_burst_tracker #(
        .DataWidth(64),
        .MaxSize  (6)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .link_h2d_i (h2d),
        .link_d2h_i (d2h),
        .req_len_o  (req_len),
        .req_idx_o  (req_idx),
        .req_left_o (req_left),
        .req_first_o(req_first),
        .req_last_o (req_last),
        .prb_len_o  (prb_len),
        .prb_idx_o  (prb_idx),
        .prb_left_o (prb_left),
        .prb_first_o(prb_first),
        .prb_last_o (prb_last),
        .rel_len_o  (rel_len),
        .rel_idx_o  (rel_idx),
        .rel_left_o (rel_left),
        .rel_first_o(rel_first),
        .rel_last_o (rel_last),
        .gnt_len_o  (gnt_len),
        .gnt_idx_o  (gnt_idx),
        .gnt_left_o (gnt_left),
        .gnt_first_o(gnt_first),
        .gnt_last_o (gnt_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus();
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkBeat(input string ch, input logic [2:0] olen, input logic [2:0] oidx,
                             input logic [2:0] oleft, input logic ofirst, input logic olast,
                             input logic [2:0] elen, input logic [2:0] eidx);
        logic [2:0] eleft;
        eleft = elen - eidx;
        checkOutput({ch, "_len"},   32'(olen),   32'(elen));
        checkOutput({ch, "_idx"},   32'(oidx),   32'(eidx));
        checkOutput({ch, "_left"},  32'(oleft),  32'(eleft));
        checkOutput({ch, "_first"}, 32'(ofirst), 32'(eidx == 3'd0));
        checkOutput({ch, "_last"},  32'(olast),  32'(eidx == elen));
    endtask

    initial begin
        logic [2:0] exp_idx;
        rst = 1'b1;
        h2d = '0;
        d2h = '0;
        repeat (2) tick();
        rst = 1'b0;
        applyStimulus();
        $display("[TB] reset state");
        checkBeat("rst_req", req_len, req_idx, req_left, req_first, req_last, 3'd0, 3'd0);
        checkBeat("rst_prb", prb_len, prb_idx, prb_left, prb_first, prb_last, 3'd0, 3'd0);
        checkBeat("rst_rel", rel_len, rel_idx, rel_left, rel_first, rel_last, 3'd0, 3'd0);
        checkBeat("rst_gnt", gnt_len, gnt_idx, gnt_left, gnt_first, gnt_last, 3'd0, 3'd0);

        $display("[TB] A PutFullData size 6 with gaps");
        tick();
        h2d.a_valid   = 1'b1;
        h2d.a.opcode  = PutFullData;
        h2d.a.size    = 3'd6;
        h2d.a.address = 56'h1000;
        for (int b = 0; b < 8; b++) begin
            if (b % 2 == 1) begin
                d2h.a_ready = 1'b0;
                applyStimulus();
                checkBeat("a_gap", req_len, req_idx, req_left, req_first, req_last, 3'd7, 3'(b));
                tick();
            end
            d2h.a_ready = 1'b1;
            applyStimulus();
            checkBeat("a_beat", req_len, req_idx, req_left, req_first, req_last, 3'd7, 3'(b));
            tick();
        end
        h2d.a_valid = 1'b0;
        applyStimulus();
        checkOutput("a_idx_after", 32'(req_idx), 32'd0);

        $display("[TB] single-beat A Get and D AccessAckData");
        tick();
        h2d.a_valid  = 1'b1;
        h2d.a.opcode = Get;
        h2d.a.size   = 3'd6;
        applyStimulus();
        checkBeat("a_get", req_len, req_idx, req_left, req_first, req_last, 3'd0, 3'd0);
        tick();
        h2d.a_valid = 1'b0;
        applyStimulus();
        checkOutput("a_get_idx_after", 32'(req_idx), 32'd0);
        d2h.d_valid  = 1'b1;
        d2h.d.opcode = DAccessAckData;
        d2h.d.size   = 3'd3;
        h2d.d_ready  = 1'b1;
        applyStimulus();
        checkBeat("d_ackdata", gnt_len, gnt_idx, gnt_left, gnt_first, gnt_last, 3'd0, 3'd0);
        tick();
        d2h.d_valid = 1'b0;
        applyStimulus();
        checkOutput("d_ack_idx_after", 32'(gnt_idx), 32'd0);

        $display("[TB] D GrantData size 6 with backpressure");
        tick();
        d2h.d_valid  = 1'b1;
        d2h.d.opcode = GrantData;
        d2h.d.size   = 3'd6;
        exp_idx = 3'd0;
        for (int c = 0; c < 16; c++) begin
            h2d.d_ready = (c % 2 == 1);
            applyStimulus();
            checkBeat("d_grant", gnt_len, gnt_idx, gnt_left, gnt_first, gnt_last, 3'd7, exp_idx);
            tick();
            if (c % 2 == 1) begin
                exp_idx = (exp_idx == 3'd7) ? 3'd0 : exp_idx + 3'd1;
            end
        end
        d2h.d_valid = 1'b0;
        h2d.d_ready = 1'b0;
        applyStimulus();
        checkOutput("d_grant_idx_after", 32'(gnt_idx), 32'd0);

        $display("[TB] B PutFullData size 4");
        d2h.b_valid  = 1'b1;
        d2h.b.opcode = BPutFullData;
        d2h.b.size   = 3'd4;
        h2d.b_ready  = 1'b1;
        applyStimulus();
        checkBeat("b_beat0", prb_len, prb_idx, prb_left, prb_first, prb_last, 3'd1, 3'd0);
        tick();
        applyStimulus();
        checkBeat("b_beat1", prb_len, prb_idx, prb_left, prb_first, prb_last, 3'd1, 3'd1);
        tick();
        d2h.b_valid = 1'b0;
        applyStimulus();
        checkOutput("b_idx_after", 32'(prb_idx), 32'd0);

        $display("[TB] concurrent C ReleaseData size 5 and A PutPartialData size 4");
        h2d.c_valid  = 1'b1;
        h2d.c.opcode = ReleaseData;
        h2d.c.size   = 3'd5;
        d2h.c_ready  = 1'b1;
        h2d.a_valid  = 1'b1;
        h2d.a.opcode = PutPartialData;
        h2d.a.size   = 3'd4;
        for (int c = 0; c < 4; c++) begin
            d2h.a_ready = (c % 2 == 0);
            applyStimulus();
            checkBeat("c_rel", rel_len, rel_idx, rel_left, rel_first, rel_last, 3'd3, 3'(c));
            checkBeat("a_pp", req_len, req_idx, req_left, req_first, req_last, 3'd1,
                      (c == 1 || c == 2) ? 3'd1 : 3'd0);
            tick();
        end
        h2d.c_valid = 1'b0;
        applyStimulus();
        checkOutput("c_idx_after", 32'(rel_idx), 32'd0);
        checkOutput("a_pp_idx_after", 32'(req_idx), 32'd0);

        $display("[TB] reset in the middle of an A burst");
        h2d.a.opcode = PutFullData;
        h2d.a.size   = 3'd6;
        d2h.a_ready  = 1'b1;
        repeat (3) tick();
        applyStimulus();
        checkBeat("a_pre_rst", req_len, req_idx, req_left, req_first, req_last, 3'd7, 3'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus();
        checkOutput("a_rst_idx", 32'(req_idx), 32'd0);
        checkOutput("a_rst_first", 32'(req_first), 32'd1);
        tick();
        applyStimulus();
        checkBeat("a_post_rst", req_len, req_idx, req_left, req_first, req_last, 3'd7, 3'd1);

        $display("[TB] oversize A header saturates");
        h2d.a_valid = 1'b0;
        h2d.a.size  = 3'd7;
        applyStimulus();
        checkOutput("a_oversize_len", 32'(req_len), 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
